// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: sequential sign-magnitude multiply-accumulate neuron.
//
// Accepts N_IN (n_in, wgh) sample pairs, accumulates their fixed-point
// products, adds a bias, applies a selectable activation and presents the
// registered result on a valid/ready output handshake.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous active-high reset
//   clr        - synchronous abort of the current evaluation
//   n_in, wgh  - activation sample and weight (sign-magnitude, FRAC fraction bits)
//   in_valid   - n_in/wgh valid
//   in_ready   - block accepts a sample (ACC state)
//   bias       - bias value, sampled in BIAS state
//   act_mode   - 00 identity, 01 ReLU, 10 leaky ReLU, 11 ReLU
//   n_out      - registered neuron result
//   out_valid  - n_out valid
//   out_ready  - downstream accepts n_out
//   sat        - saturation occurred during the evaluation producing n_out
module neuron_mac_seq #(
    parameter int W    = 16,
    parameter int FRAC = 7,
    parameter int N_IN = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] n_in,
    input  logic [W-1:0] wgh,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] bias,
    input  logic [1:0]   act_mode,
    output logic [W-1:0] n_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         sat
);

    localparam int MW = W - 1;
    localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [MW-1:0] MAXM = '1;

    typedef enum logic [1:0] {
        ACC,
        BIAS,
        OUT
    } state_t;

    state_t          state;
    logic [W-1:0]    acc;
    logic [CW-1:0]   cnt;
    logic            sat_acc;

    logic [W:0]      prod;      // {sat, sign, magnitude}
    logic [W:0]      mac_sum;   // {sat, sign, magnitude}
    logic [W:0]      bias_sum;  // {sat, sign, magnitude}
    logic [W-1:0]    act_val;
    logic            last;

    // Fixed-point product; magnitude truncated after the FRAC shift and
    // clamped to the largest representable magnitude.
    function automatic logic [W:0] sm_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*MW-1:0] p;
        logic [2*MW-1:0] ps;
        logic [MW-1:0]   m;
        logic            s;
        logic            sg;
        p  = {{MW{1'b0}}, a[MW-1:0]} * {{MW{1'b0}}, b[MW-1:0]};
        ps = p >> FRAC;
        if (ps > {{MW{1'b0}}, MAXM}) begin
            m = MAXM;
            s = 1'b1;
        end else begin
            m = ps[MW-1:0];
            s = 1'b0;
        end
        sg = (m == '0) ? 1'b0 : (a[W-1] ^ b[W-1]);
        return {s, sg, m};
    endfunction

    // Sign-magnitude add with saturation; a zero result is always +0.
    function automatic logic [W:0] sm_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [MW:0]   sum;
        logic [MW-1:0] m;
        logic          s;
        logic          sg;
        s = 1'b0;
        if (a[W-1] == b[W-1]) begin
            sum = {1'b0, a[MW-1:0]} + {1'b0, b[MW-1:0]};
            sg  = a[W-1];
            if (sum[MW]) begin
                m = MAXM;
                s = 1'b1;
            end else begin
                m = sum[MW-1:0];
            end
        end else if (a[MW-1:0] >= b[MW-1:0]) begin
            m  = a[MW-1:0] - b[MW-1:0];
            sg = a[W-1];
        end else begin
            m  = b[MW-1:0] - a[MW-1:0];
            sg = b[W-1];
        end
        if (m == '0) begin
            sg = 1'b0;
        end
        return {s, sg, m};
    endfunction

    function automatic logic [W-1:0] activate(input logic [W-1:0] v, input logic [1:0] mode);
        logic [MW-1:0] m;
        logic [W-1:0]  r;
        m = v[MW-1:0] >> 3;
        if (!v[W-1]) begin
            r = v;
        end else begin
            case (mode)
                2'b00:   r = v;
                2'b10:   r = (m == '0) ? '0 : {1'b1, m};
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    always_comb begin
        prod     = sm_mul(n_in, wgh);
        mac_sum  = sm_add(acc, prod[W-1:0]);
        bias_sum = sm_add(acc, bias);
        act_val  = activate(bias_sum[W-1:0], act_mode);
        last     = (cnt == CW'(N_IN - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            sat_acc   <= 1'b0;
            n_out     <= '0;
            out_valid <= 1'b0;
            sat       <= 1'b0;
            in_ready  <= 1'b1;
        end else if (clr) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            sat_acc   <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                ACC: begin
                    if (in_valid) begin
                        acc     <= mac_sum[W-1:0];
                        sat_acc <= sat_acc | prod[W] | mac_sum[W];
                        if (last) begin
                            cnt      <= '0;
                            state    <= BIAS;
                            in_ready <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                BIAS: begin
                    n_out     <= act_val;
                    sat       <= sat_acc | bias_sum[W];
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        sat_acc   <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACC;
                    end
                end
                default: begin
                    state    <= ACC;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
